// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM states, owner
// encoding and store-size codes.
package mem_arbiter_pkg;

    localparam logic [1:0] EXE_MEMWDSRC_B = 2'b00;
    localparam logic [1:0] EXE_MEMWDSRC_H = 2'b01;
    localparam logic [1:0] EXE_MEMWDSRC_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } arb_owner_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and bus handshake signals of the arbiter. The slave modport is
// the arbiter's view; the master modport is the surrounding core/memory view.
interface mem_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [1:0]  d_wdsrc;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_wdsrc, d_addr, d_wdata,
               bus_gnt, bus_rvalid, bus_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               bus_req, bus_addr, bus_we, bus_be, bus_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_wdsrc, d_addr, d_wdata,
               bus_gnt, bus_rvalid, bus_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               bus_req, bus_addr, bus_we, bus_be, bus_wdata
    );

endinterface

// File: rtl/mem_arbiter_store_lane_gen.sv
// Byte-enable generation, store-data lane replication and alignment check
// for a data access of the given size and low address bits.
module store_lane_gen
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  i_wdsrc,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misalign
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
        o_misalign = 1'b0;
        case (i_wdsrc)
            EXE_MEMWDSRC_B: begin
                o_be    = 4'b0001 << i_addr;
                o_wdata = {4{i_wdata[7:0]}};
            end
            EXE_MEMWDSRC_H: begin
                o_be       = 4'b0011 << {i_addr[1], 1'b0};
                o_wdata    = {2{i_wdata[15:0]}};
                o_misalign = i_addr[0];
            end
            EXE_MEMWDSRC_W: begin
                o_misalign = |i_addr;
            end
            default: begin
                // Unencoded size is never sent to the bus.
                o_misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch, data) arbiter onto a single request/response
// memory bus with one outstanding transaction and fetch starvation protection.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave arb
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_e       r_state;
    arb_owner_e       r_owner;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_bus_req;
    logic [31:0]      r_bus_addr;
    logic             r_bus_we;
    logic [3:0]       r_bus_be;
    logic [31:0]      r_bus_wdata;

    logic [3:0]  w_lane_be;
    logic [31:0] w_lane_wdata;
    logic        w_misalign;
    logic        w_starved;
    logic        w_sel_data;
    logic        w_sel_fetch;
    logic        w_idle;
    logic        w_req;
    logic        w_rsp;
    logic        w_d_err;

    store_lane_gen u_lane (
        .i_wdsrc    (arb.d_wdsrc),
        .i_addr     (arb.d_addr[1:0]),
        .i_wdata    (arb.d_wdata),
        .o_be       (w_lane_be),
        .o_wdata    (w_lane_wdata),
        .o_misalign (w_misalign)
    );

    assign w_idle      = (r_state == ST_IDLE);
    assign w_req       = (r_state == ST_REQ);
    assign w_rsp       = (r_state == ST_RSP);
    assign w_starved   = arb.if_req && (r_starve_cnt == LIMIT);
    assign w_sel_data  = arb.d_req && !w_starved;
    assign w_sel_fetch = arb.if_req && !w_sel_data;
    // Reset forces IDLE, but the error pulse is combinational from inputs.
    assign w_d_err     = w_idle && w_sel_data && w_misalign && !reset;

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_FETCH;
            r_starve_cnt <= '0;
            r_bus_req    <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_we     <= 1'b0;
            r_bus_be     <= '0;
            r_bus_wdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_data) begin
                        if (arb.if_req && (r_starve_cnt != LIMIT))
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        if (!w_misalign) begin
                            r_owner     <= OWN_DATA;
                            r_bus_req   <= 1'b1;
                            r_bus_addr  <= word_align(arb.d_addr);
                            r_bus_we    <= arb.d_we;
                            r_bus_be    <= w_lane_be;
                            r_bus_wdata <= w_lane_wdata;
                            r_state     <= ST_REQ;
                        end
                    end else if (w_sel_fetch) begin
                        r_starve_cnt <= '0;
                        r_owner      <= OWN_FETCH;
                        r_bus_req    <= 1'b1;
                        r_bus_addr   <= word_align(arb.if_addr);
                        r_bus_we     <= 1'b0;
                        r_bus_be     <= 4'b1111;
                        r_bus_wdata  <= '0;
                        r_state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (arb.bus_gnt) begin
                        r_bus_req <= 1'b0;
                        r_state   <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (arb.bus_rvalid)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign arb.bus_req   = r_bus_req;
    assign arb.bus_addr  = r_bus_addr;
    assign arb.bus_we    = r_bus_we;
    assign arb.bus_be    = r_bus_be;
    assign arb.bus_wdata = r_bus_wdata;

    assign arb.if_gnt    = w_req && (r_owner == OWN_FETCH) && arb.bus_gnt;
    assign arb.d_gnt     = (w_req && (r_owner == OWN_DATA) && arb.bus_gnt) || w_d_err;
    assign arb.d_err     = w_d_err;

    assign arb.if_rvalid = w_rsp && (r_owner == OWN_FETCH) && arb.bus_rvalid;
    assign arb.d_rvalid  = w_rsp && (r_owner == OWN_DATA) && arb.bus_rvalid;
    assign arb.if_rdata  = (w_rsp && (r_owner == OWN_FETCH)) ? arb.bus_rdata : '0;
    assign arb.d_rdata   = (w_rsp && (r_owner == OWN_DATA)) ? arb.bus_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: data-access vector table, fetch path,
// starvation grant order, bus stall and mid-transaction reset.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if bus_if ();

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (bus_if.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.if_req     = 1'b0;
        bus_if.if_addr    = '0;
        bus_if.d_req      = 1'b0;
        bus_if.d_we       = 1'b0;
        bus_if.d_wdsrc    = EXE_MEMWDSRC_W;
        bus_if.d_addr     = '0;
        bus_if.d_wdata    = '0;
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  wdsrc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, EXE_MEMWDSRC_B, 32'h0000_0203, 32'h0000_00AB, 1'b0, 4'b1000, 32'hABAB_ABAB};
        vecs[1] = '{1'b1, EXE_MEMWDSRC_H, 32'h0000_0202, 32'h0000_1234, 1'b0, 4'b1100, 32'h1234_1234};
        vecs[2] = '{1'b1, EXE_MEMWDSRC_W, 32'h0000_0100, 32'hCAFE_F00D, 1'b0, 4'b1111, 32'hCAFE_F00D};
        vecs[3] = '{1'b1, EXE_MEMWDSRC_W, 32'h0000_0102, 32'h1111_1111, 1'b1, 4'b0000, 32'h0};
        vecs[4] = '{1'b0, EXE_MEMWDSRC_H, 32'h0000_0101, 32'h0000_0000, 1'b1, 4'b0000, 32'h0};
        vecs[5] = '{1'b0, EXE_MEMWDSRC_B, 32'h0000_0301, 32'h0000_0000, 1'b0, 4'b0010, 32'h0};
        vecs[6] = '{1'b0, EXE_MEMWDSRC_H, 32'h0000_0206, 32'h0000_0000, 1'b0, 4'b1100, 32'h0};
        vecs[7] = '{1'b1, EXE_MEMWDSRC_B, 32'h0000_0000, 32'h0000_01FF, 1'b0, 4'b0001, 32'hFFFF_FFFF};
        vecs[8] = '{1'b1, 2'b11,          32'h0000_0100, 32'h0000_0005, 1'b1, 4'b0000, 32'h0};
        vecs[9] = '{1'b1, EXE_MEMWDSRC_H, 32'h0000_0200, 32'hFFFF_0001, 1'b0, 4'b0011, 32'h0001_0001};

        clear_inputs();
        reset = 1'b1;
        #2;
        check("rst_bus_req",   bus_if.bus_req,   0);
        check("rst_bus_addr",  bus_if.bus_addr,  0);
        check("rst_bus_be",    bus_if.bus_be,    0);
        check("rst_bus_wdata", bus_if.bus_wdata, 0);
        check("rst_gnt",       {bus_if.if_gnt, bus_if.d_gnt, bus_if.d_err}, 0);
        check("rst_rvalid",    {bus_if.if_rvalid, bus_if.d_rvalid}, 0);
        step();
        reset = 1'b0;
        step();

        // Fetch path with a zero-wait bus.
        bus_if.bus_gnt = 1'b1;
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h0000_0100;
        #1;
        check("f_idle_bus_req", bus_if.bus_req, 0);
        step();
        check("f_bus_req",  bus_if.bus_req,  1);
        check("f_bus_addr", bus_if.bus_addr, 32'h100);
        check("f_bus_be",   bus_if.bus_be,   4'hF);
        check("f_bus_we",   bus_if.bus_we,   0);
        check("f_if_gnt",   bus_if.if_gnt,   1);
        check("f_d_gnt",    bus_if.d_gnt,    0);
        step();
        bus_if.if_req     = 1'b0;
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 32'hDEAD_BEEF;
        #1;
        check("f_if_rvalid", bus_if.if_rvalid, 1);
        check("f_if_rdata",  bus_if.if_rdata,  32'hDEAD_BEEF);
        check("f_d_rvalid",  bus_if.d_rvalid,  0);
        step();
        bus_if.bus_rvalid = 1'b0;
        check("f_back_idle", bus_if.bus_req, 0);

        // Data-access vector table.
        for (int i = 0; i < 10; i++) begin
            bus_if.d_we    = vecs[i].we;
            bus_if.d_wdsrc = vecs[i].wdsrc;
            bus_if.d_addr  = vecs[i].addr;
            bus_if.d_wdata = vecs[i].wdata;
            bus_if.d_req   = 1'b1;
            #1;
            check($sformatf("v%0d_err", i),  bus_if.d_err, vecs[i].exp_err);
            check($sformatf("v%0d_gnt0", i), bus_if.d_gnt, vecs[i].exp_err);
            if (vecs[i].exp_err) begin
                step();
                bus_if.d_req = 1'b0;
                check($sformatf("v%0d_no_bus_req", i), bus_if.bus_req, 0);
                #1;
                check($sformatf("v%0d_err_clear", i), bus_if.d_err, 0);
                step();
            end else begin
                step();
                check($sformatf("v%0d_bus_req", i),   bus_if.bus_req,   1);
                check($sformatf("v%0d_bus_addr", i),  bus_if.bus_addr,  vecs[i].addr & 32'hFFFF_FFFC);
                check($sformatf("v%0d_bus_be", i),    bus_if.bus_be,    vecs[i].exp_be);
                check($sformatf("v%0d_bus_wdata", i), bus_if.bus_wdata, vecs[i].exp_wdata);
                check($sformatf("v%0d_bus_we", i),    bus_if.bus_we,    vecs[i].we);
                check($sformatf("v%0d_d_gnt", i),     bus_if.d_gnt,     1);
                check($sformatf("v%0d_if_gnt", i),    bus_if.if_gnt,    0);
                step();
                bus_if.d_req      = 1'b0;
                bus_if.bus_rvalid = 1'b1;
                bus_if.bus_rdata  = 32'h1000_0000 + i;
                #1;
                check($sformatf("v%0d_d_rvalid", i),  bus_if.d_rvalid,  1);
                check($sformatf("v%0d_d_rdata", i),   bus_if.d_rdata,   32'h1000_0000 + i);
                check($sformatf("v%0d_if_rvalid", i), bus_if.if_rvalid, 0);
                step();
                bus_if.bus_rvalid = 1'b0;
            end
        end

        // Both requesters held continuously: fetch wins every fifth grant.
        clear_inputs();
        pulse_reset();
        begin
            string exp_order;
            int    n;
            exp_order = "DDDDFDDDDF";
            n = 0;
            bus_if.if_req     = 1'b1;
            bus_if.if_addr    = 32'h0000_0500;
            bus_if.d_req      = 1'b1;
            bus_if.d_we       = 1'b0;
            bus_if.d_wdsrc    = EXE_MEMWDSRC_W;
            bus_if.d_addr     = 32'h0000_0400;
            bus_if.bus_gnt    = 1'b1;
            bus_if.bus_rvalid = 1'b1;
            for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
                step();
                if (bus_if.if_gnt || bus_if.d_gnt) begin
                    logic [7:0] got;
                    got = bus_if.if_gnt ? 8'h46 : 8'h44;
                    check($sformatf("starve_grant%0d_both", n), {bus_if.if_gnt, bus_if.d_gnt} == 2'b11, 0);
                    check($sformatf("starve_grant%0d", n), got, exp_order[n]);
                    n++;
                end
            end
            if (n < 10) check("starve_timeout", n, 10);
            bus_if.if_req = 1'b0;
            bus_if.d_req  = 1'b0;
            step();
            step();
            step();
            clear_inputs();
        end

        // Bus stall for five cycles, then reset while in RSP.
        pulse_reset();
        bus_if.d_we    = 1'b1;
        bus_if.d_wdsrc = EXE_MEMWDSRC_B;
        bus_if.d_addr  = 32'h0000_0203;
        bus_if.d_wdata = 32'h0000_00AB;
        bus_if.d_req   = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d_bus_req", k),   bus_if.bus_req,   1);
            check($sformatf("stall%0d_bus_addr", k),  bus_if.bus_addr,  32'h200);
            check($sformatf("stall%0d_bus_be", k),    bus_if.bus_be,    4'b1000);
            check($sformatf("stall%0d_bus_wdata", k), bus_if.bus_wdata, 32'hABAB_ABAB);
            check($sformatf("stall%0d_bus_we", k),    bus_if.bus_we,    1);
            check($sformatf("stall%0d_d_gnt", k),     bus_if.d_gnt,     0);
            step();
        end
        bus_if.bus_gnt = 1'b1;
        #1;
        check("stall_release_gnt", bus_if.d_gnt, 1);
        step();
        bus_if.d_req      = 1'b0;
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 32'h1234_5678;
        reset = 1'b1;
        #1;
        check("rsp_rst_bus_req",   bus_if.bus_req,   0);
        check("rsp_rst_bus_addr",  bus_if.bus_addr,  0);
        check("rsp_rst_bus_be",    bus_if.bus_be,    0);
        check("rsp_rst_bus_wdata", bus_if.bus_wdata, 0);
        check("rsp_rst_bus_we",    bus_if.bus_we,    0);
        check("rsp_rst_d_rvalid",  bus_if.d_rvalid,  0);
        check("rsp_rst_d_rdata",   bus_if.d_rdata,   0);
        // A misaligned request during reset must not pulse grant/error.
        bus_if.d_wdsrc = EXE_MEMWDSRC_W;
        bus_if.d_addr  = 32'h0000_0102;
        bus_if.d_req   = 1'b1;
        #1;
        check("rst_misalign_gnt", bus_if.d_gnt, 0);
        check("rst_misalign_err", bus_if.d_err, 0);
        bus_if.d_req = 1'b0;
        step();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("late_rvalid%0d_d", k),  bus_if.d_rvalid,  0);
            check($sformatf("late_rvalid%0d_if", k), bus_if.if_rvalid, 0);
            check($sformatf("late_rvalid%0d_rd", k), bus_if.d_rdata,   0);
        end
        bus_if.bus_rvalid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive data grants allowed while fetch waits before fetch is forced to win.
REQ-002 SHALL have ports, with clock and reset listed first:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  32  fetch word address.
- if_gnt  out  1  fetch request accepted by bus.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  32  fetch read data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_wdsrc  in  2  store size, `EXE_MEMWDSRC_B/H/W.
- d_addr  in  32  byte address.
- d_wdata  in  32  store data, right-aligned.
- d_gnt  out  1  data request accepted.
- d_rvalid  out  1  load data valid or store acknowledged.
- d_rdata  out  32  raw bus word.
- d_err  out  1  misaligned access, pulsed with d_gnt.
- bus_req  out  1  registered bus request.
- bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- bus_we  out  1  bus write.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_gnt  in  1  bus accepted request.
- bus_rvalid  in  1  bus response (reads and writes).
- bus_rdata  in  32  bus read data.

Function
REQ-003 SHALL implement FSM with states IDLE, REQ, RSP; one outstanding transaction maximum.
REQ-004 In IDLE with any request pending, SHALL select an owner, latch its address, we, be and wdata into bus registers, and go to REQ the next cycle.
REQ-005 SHALL select data over fetch, unless starve_cnt equals STARVE_LIMIT and if_req is high, in which case fetch SHALL be selected.
REQ-006 SHALL increment starve_cnt, saturating at STARVE_LIMIT, on each data selection while if_req is high, and clear it on each fetch selection.
REQ-007 In REQ, SHALL hold bus_req=1 with all bus_* outputs stable until bus_gnt, then go to RSP.
REQ-008 SHALL drive the owner's gnt combinationally equal to bus_gnt during REQ; the non-owner's gnt SHALL be 0.
REQ-009 In RSP, SHALL route bus_rvalid and bus_rdata to the owner's rvalid/rdata in the same cycle, then return to IDLE.
REQ-010 A fetch SHALL use bus_we=0 and bus_be=4'b1111.
REQ-011 Byte enables SHALL be:
- B: 4'b0001<<addr[1:0].
- H: 4'b0011<<{addr[1],1'b0}.
- W: 4'b1111.
REQ-012 bus_wdata SHALL be:
- B: {4{wdata[7:0]}}.
- H: {2{wdata[15:0]}}.
- W: wdata.
REQ-013 Data loads SHALL use bus_be as in REQ-011, so memory can gate reads.
REQ-014 A misaligned data access (H with addr[0]=1; W with addr[1:0]!=0) selected in IDLE SHALL assert d_gnt=1 and d_err=1 for that one cycle, issue no bus request, stay in IDLE, and count as a data selection per REQ-006.
REQ-015 An invalid d_wdsrc (2'b11) on a store SHALL be treated as misaligned.
REQ-016 Simultaneous if_req and d_req SHALL be resolved only by REQ-005; the losing request remains pending with gnt=0.
REQ-017 A request deasserted before its gnt violates protocol; behaviour is not required to be defined.
REQ-018 Latency with zero-wait bus: request cycle N -> bus_req cycle N+1 -> gnt cycle N+1 -> rvalid earliest cycle N+2; back-to-back issue every 3 cycles.

Reset
REQ-019 On reset, SHALL asynchronously enter IDLE and clear starve_cnt, bus_req, bus_we, bus_be, bus_addr and bus_wdata to 0.
REQ-020 During reset, if_gnt, d_gnt, if_rvalid, d_rvalid and d_err SHALL be 0, and if_rdata and d_rdata SHALL be 0.
REQ-021 Reset mid-transaction SHALL abandon it; a late bus_rvalid received in IDLE SHALL be ignored.

Structure
REQ-022 The FSM state enum and owner encoding SHALL live in the shared defines package; `EXE_MEMWDSRC_* SHALL be reused from there.
REQ-023 Byte-enable and lane-replication logic SHALL be one sub-module, store_lane_gen (inputs wdsrc, addr[1:0], wdata; outputs be, wdata_out, misalign).

Verification
REQ-024 Fetch only: if_req=1, if_addr=0x100, bus_gnt immediate, bus_rvalid next cycle with 0xDEADBEEF -> bus_addr=0x100, bus_be=4'hF, if_rvalid=1 with if_rdata=0xDEADBEEF.
REQ-025 SB: d_addr=0x203, d_wdata=0xAB -> bus_addr=0x200, bus_be=4'b1000, bus_wdata=0xABABABAB, bus_we=1; SH at 0x202 -> bus_be=4'b1100.
REQ-026 Both requests held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F.
REQ-027 SW at 0x102 -> d_gnt=1 and d_err=1 in the same cycle, bus_req stays 0; LH at 0x101 behaves the same.
REQ-028 bus_gnt held low for 5 cycles -> bus_addr, bus_be, bus_wdata and bus_we stable throughout; reset asserted in RSP -> outputs 0 immediately, and a following bus_rvalid produces no if_rvalid or d_rvalid.
